l1d_ewrq_wb_tx: RTL and testbench

// Drain side of the L1D eviction write-back queue (EWRQ, N_EWRQ=4 entries, 512b line + 16b meta).

---
 rtl/l1d_ewrq_wb_tx.sv | 161 ++++++++++++++++
 tb/tb_l1d_ewrq_wb_tx.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1d_ewrq_wb_tx.sv
// L1D eviction write-back drain: pops EWRQ entries and serialises them as NoC packets
// (header flit plus line beats when dirty), tracking un-acked write-backs up to MAX_OUT.
module l1d_ewrq_wb_tx #(
  parameter int unsigned FLIT_W  = 128,
  parameter logic [3:0]  SRC_ID  = 4'd0,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              deq_vld_i,
  input  logic [15:0]       deq_meta_i,
  input  logic [511:0]      deq_data_i,
  output logic              deq_rdy_o,
  output logic              flit_vld_o,
  output logic [FLIT_W-1:0] flit_o,
  output logic              flit_last_o,
  input  logic              flit_rdy_i,
  input  logic              ack_vld_i,
  output logic [3:0]        out_cnt_o,
  output logic              busy_o
);

  localparam int unsigned NBEATS = 512 / FLIT_W;
  localparam int unsigned BeatW  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(NBEATS - 1);

  localparam logic [1:0] MesiI = 2'b00;
  localparam logic [1:0] MesiM = 2'b11;
  localparam logic [1:0] TypeDirty = 2'b01;
  localparam logic [1:0] TypeClean = 2'b10;

  typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

  state_e             state_q, state_d;
  logic               dirty_q, dirty_d;
  logic [511:0]       data_q, data_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [FLIT_W-1:0]  flit_q, flit_d;
  logic               flit_vld_q, flit_vld_d;
  logic               flit_last_q, flit_last_d;
  logic [3:0]         out_cnt_q, out_cnt_d;

  logic              deq_fire;
  logic              hdr_fire;
  logic              ack_take;
  logic [1:0]        deq_mesi;
  logic [FLIT_W-1:0] hdr_flit;

  assign deq_mesi  = deq_meta_i[15:14];
  assign deq_rdy_o = (state_q == StIdle) && (32'(out_cnt_q) < MAX_OUT);
  assign deq_fire  = deq_vld_i && deq_rdy_o;
  assign hdr_fire  = (state_q == StHdr) && flit_rdy_i;
  // Acks with nothing outstanding are spurious and dropped.
  assign ack_take  = ack_vld_i && (out_cnt_q != 4'd0);

  always_comb begin
    hdr_flit = '0;
    hdr_flit[FLIT_W-1 -: 2] = (deq_mesi == MesiM) ? TypeDirty : TypeClean;
    hdr_flit[FLIT_W-3 -: 4] = SRC_ID;
    hdr_flit[13:0]          = deq_meta_i[13:0];
  end

  always_comb begin
    state_d     = state_q;
    dirty_d     = dirty_q;
    data_d      = data_q;
    beat_d      = beat_q;
    flit_d      = flit_q;
    flit_vld_d  = flit_vld_q;
    flit_last_d = flit_last_q;
    unique case (state_q)
      StIdle: begin
        if (deq_fire && (deq_mesi != MesiI)) begin
          dirty_d     = (deq_mesi == MesiM);
          data_d      = deq_data_i;
          flit_d      = hdr_flit;
          flit_last_d = (deq_mesi != MesiM);
          flit_vld_d  = 1'b1;
          state_d     = StHdr;
        end
      end
      StHdr: begin
        if (flit_rdy_i) begin
          if (dirty_q) begin
            // Line is shifted down so the next beat is always in the low slice.
            beat_d      = '0;
            flit_d      = data_q[FLIT_W-1:0];
            data_d      = data_q >> FLIT_W;
            flit_last_d = (LastBeat == '0);
            state_d     = StData;
          end else begin
            flit_d      = '0;
            flit_last_d = 1'b0;
            flit_vld_d  = 1'b0;
            state_d     = StIdle;
          end
        end
      end
      StData: begin
        if (flit_rdy_i) begin
          if (beat_q == LastBeat) begin
            flit_d      = '0;
            flit_last_d = 1'b0;
            flit_vld_d  = 1'b0;
            state_d     = StIdle;
          end else begin
            beat_d      = beat_q + 1'b1;
            flit_d      = data_q[FLIT_W-1:0];
            data_d      = data_q >> FLIT_W;
            flit_last_d = (beat_d == LastBeat);
          end
        end
      end
      default: begin
        flit_vld_d = 1'b0;
        state_d    = StIdle;
      end
    endcase
  end

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (hdr_fire && !ack_take) begin
      out_cnt_d = out_cnt_q + 4'd1;
    end else if (!hdr_fire && ack_take) begin
      out_cnt_d = out_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      dirty_q     <= 1'b0;
      beat_q      <= '0;
      flit_q      <= '0;
      flit_vld_q  <= 1'b0;
      flit_last_q <= 1'b0;
      out_cnt_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      dirty_q     <= dirty_d;
      beat_q      <= beat_d;
      flit_q      <= flit_d;
      flit_vld_q  <= flit_vld_d;
      flit_last_q <= flit_last_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  // Line buffer needs no reset; it is only read after being loaded on a pop.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign flit_vld_o  = flit_vld_q;
  assign flit_o      = flit_q;
  assign flit_last_o = flit_last_q;
  assign out_cnt_o   = out_cnt_q;
  assign busy_o      = (state_q != StIdle) || (out_cnt_q != 4'd0);

endmodule

// File: tb/tb_l1d_ewrq_wb_tx.sv
// Scoreboard bench for l1d_ewrq_wb_tx: expected flits are queued at pop time and
// compared as the DUT fires them on the NoC side.
module tb_l1d_ewrq_wb_tx;

  localparam int unsigned FW = 128;
  localparam logic [3:0]  SRC = 4'd5;

  logic          clk = 1'b0;
  logic          rst;
  logic          deq_vld_i;
  logic [15:0]   deq_meta_i;
  logic [511:0]  deq_data_i;
  logic          deq_rdy_o;
  logic          flit_vld_o;
  logic [FW-1:0] flit_o;
  logic          flit_last_o;
  logic          flit_rdy_i;
  logic          ack_vld_i;
  logic [3:0]    out_cnt_o;
  logic          busy_o;

  int checks   = 0;
  int failures = 0;
  int n_fire   = 0;

  logic [FW:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [FW:0] prev_flit;

  l1d_ewrq_wb_tx #(.FLIT_W(FW), .SRC_ID(SRC), .MAX_OUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .deq_vld_i  (deq_vld_i),
    .deq_meta_i (deq_meta_i),
    .deq_data_i (deq_data_i),
    .deq_rdy_o  (deq_rdy_o),
    .flit_vld_o (flit_vld_o),
    .flit_o     (flit_o),
    .flit_last_o(flit_last_o),
    .flit_rdy_i (flit_rdy_i),
    .ack_vld_i  (ack_vld_i),
    .out_cnt_o  (out_cnt_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  // Output monitor: inputs change at posedge+1, so negedge sees settled values.
  always @(negedge clk) begin
    logic [FW:0] e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (flit_vld_o !== 1'b1 || {flit_last_o, flit_o} !== prev_flit) begin
          failures++;
          $display("FAIL stall_hold: vld=%0b flit=%0h required vld=1 flit=%0h",
                   flit_vld_o, {flit_last_o, flit_o}, prev_flit);
        end
      end
      if (flit_vld_o && flit_rdy_i) begin
        n_fire++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_flit: got %0h, required none", {flit_last_o, flit_o});
        end else begin
          e = exp_q.pop_front();
          if ({flit_last_o, flit_o} !== e) begin
            failures++;
            $display("FAIL flit_data: got %0h required %0h", {flit_last_o, flit_o}, e);
          end
        end
      end
      prev_stall = flit_vld_o && !flit_rdy_i;
      prev_flit  = {flit_last_o, flit_o};
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one pop (assumes called at posedge+1) and queues the flits it should produce.
  task automatic pop(input logic [15:0] meta, input logic [511:0] data);
    logic [FW-1:0] hdr;
    deq_vld_i  = 1'b1;
    deq_meta_i = meta;
    deq_data_i = data;
    checks++;
    if (deq_rdy_o !== 1'b1) begin
      failures++;
      $display("FAIL pop_rdy: deq_rdy_o=%0b required 1", deq_rdy_o);
    end
    if (meta[15:14] != 2'b00) begin
      hdr = '0;
      hdr[FW-1:FW-2] = (meta[15:14] == 2'b11) ? 2'b01 : 2'b10;
      hdr[FW-3:FW-6] = SRC;
      hdr[13:0]      = meta[13:0];
      exp_q.push_back({(meta[15:14] != 2'b11), hdr});
      if (meta[15:14] == 2'b11) begin
        for (int k = 0; k < 512 / FW; k++) begin
          exp_q.push_back({(k == 512 / FW - 1), data[k*FW +: FW]});
        end
      end
    end
    cyc(1);
    deq_vld_i = 1'b0;
  endtask

  task automatic ack_pulse();
    ack_vld_i = 1'b1;
    cyc(1);
    ack_vld_i = 1'b0;
  endtask

  task automatic check_cnt(input string name, input logic [3:0] want);
    checks++;
    if (out_cnt_o !== want) begin
      failures++;
      $display("FAIL %s: out_cnt_o=%0d required %0d", name, out_cnt_o, want);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d flits outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    checks++;
    if ({flit_vld_o, flit_last_o, busy_o, deq_rdy_o} !== 4'b0001 || flit_o !== '0) begin
      failures++;
      $display("FAIL reset_outputs: vld/last/busy/rdy=%b flit=%0h required 0001 flit=0",
               {flit_vld_o, flit_last_o, busy_o, deq_rdy_o}, flit_o);
    end
    check_cnt("reset_cnt", 4'd0);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_dirty();
    logic [511:0] d;
    int f0;
    for (int k = 0; k < 4; k++) d[k*128 +: 128] = {4{32'hA000_0000 + k}};
    flit_rdy_i = 1'b1;
    f0 = n_fire;
    pop({2'b11, 14'h01A5}, d);
    cyc(5);
    checks++;
    if (n_fire - f0 != 5 || exp_q.size() != 0 || flit_vld_o !== 1'b0) begin
      failures++;
      $display("FAIL dirty_timing: fires=%0d left=%0d vld=%0b required 5 0 0",
               n_fire - f0, exp_q.size(), flit_vld_o);
    end
    check_cnt("dirty_cnt", 4'd1);
    ack_pulse();
    check_cnt("dirty_ack", 4'd0);
  endtask

  task automatic test_clean();
    flit_rdy_i = 1'b1;
    pop({2'b10, 14'h3FFF}, {16{32'hDEAD_BEEF}});
    cyc(3);
    check_cnt("clean_e_cnt", 4'd1);
    pop({2'b01, 14'h3FFF}, {16{32'h1234_5678}});
    cyc(3);
    check_cnt("clean_s_cnt", 4'd2);
    drain("clean", 4);
    ack_pulse();
    ack_pulse();
    check_cnt("clean_ack", 4'd0);
  endtask

  task automatic test_invalid();
    int f0 = n_fire;
    flit_rdy_i = 1'b1;
    pop({2'b00, 14'h0123}, {16{32'hFFFF_0000}});
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (flit_vld_o !== 1'b0) begin
        failures++;
        $display("FAIL invalid_novld: flit_vld_o=%0b required 0 (cycle %0d)", flit_vld_o, i);
      end
      cyc(1);
    end
    checks++;
    if (n_fire != f0) begin
      failures++;
      $display("FAIL invalid_fires: %0d required 0", n_fire - f0);
    end
    check_cnt("invalid_cnt", 4'd0);
  endtask

  task automatic test_stall();
    logic [511:0] d;
    logic [3:0] pat = 4'b1001;
    int i = 0;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
    flit_rdy_i = 1'b0;
    pop({2'b11, 14'h2B3C}, d);
    while (exp_q.size() != 0 && i < 40) begin
      flit_rdy_i = pat[i % 4];
      cyc(1);
      i++;
    end
    flit_rdy_i = 1'b1;
    drain("stall", 2);
    check_cnt("stall_cnt", 4'd1);
    ack_pulse();
  endtask

  task automatic test_back_to_back();
    int f0;
    flit_rdy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pop({2'b01, 14'(16 + i)}, '0);
      cyc(1);
    end
    check_cnt("throttle_full", 4'd4);
    f0 = n_fire;
    deq_vld_i  = 1'b1;
    deq_meta_i = {2'b10, 14'h0055};
    checks++;
    if (deq_rdy_o !== 1'b0) begin
      failures++;
      $display("FAIL throttle_rdy: deq_rdy_o=%0b required 0", deq_rdy_o);
    end
    cyc(2);
    deq_vld_i = 1'b0;
    checks++;
    if (n_fire != f0) begin
      failures++;
      $display("FAIL throttle_nofire: %0d fires required 0", n_fire - f0);
    end
    check_cnt("throttle_hold", 4'd4);
    ack_pulse();
    check_cnt("throttle_ack", 4'd3);
    pop({2'b10, 14'h0055}, '0);
    ack_vld_i = 1'b1;
    cyc(1);
    ack_vld_i = 1'b0;
    check_cnt("ack_and_hdr", 4'd3);
    drain("throttle", 2);
    for (int i = 0; i < 3; i++) ack_pulse();
    check_cnt("throttle_done", 4'd0);
  endtask

  task automatic test_rst_mid();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = 32'hC0DE_0000 + k;
    flit_rdy_i = 1'b1;
    pop({2'b11, 14'h0777}, d);
    cyc(3);
    rst = 1'b1;
    flit_rdy_i = 1'b0;
    cyc(1);
    exp_q.delete();
    checks++;
    if (flit_vld_o !== 1'b0 || deq_rdy_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid: vld=%0b rdy=%0b required vld=0 rdy=1", flit_vld_o, deq_rdy_o);
    end
    check_cnt("rst_mid_cnt", 4'd0);
    rst = 1'b0;
    flit_rdy_i = 1'b1;
    ack_pulse();
    check_cnt("stray_ack", 4'd0);
  endtask

  initial begin
    rst        = 1'b1;
    deq_vld_i  = 1'b0;
    deq_meta_i = '0;
    deq_data_i = '0;
    flit_rdy_i = 1'b1;
    ack_vld_i  = 1'b0;
    #1;
    test_reset();
    test_dirty();
    test_clean();
    test_invalid();
    test_stall();
    test_back_to_back();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
